// File: rtl/branch_predictor.sv
// branch_predictor: dynamic branch direction predictor.
//
// A table of 2-bit saturating counters indexed by PC[INDEX_BITS+1:2] is looked
// up combinationally for the instruction in IF and trained from branch
// resolution in EX. After reset or a clear request the block walks the whole
// table writing INIT_STATE, one entry per cycle, before reporting ready.
// It also keeps saturating branch and misprediction statistics.
//
// Ports:
//   clk               clock, rising edge
//   reset             asynchronous active-high reset
//   clear             one-cycle request to re-initialise the table
//   IF_PC, IF_opcode  instruction being fetched (branch opcode = 4'b0010)
//   prediction        predicted direction for IF_PC (1 = taken)
//   ready             table valid (RUN state), registered
//   update            one-cycle pulse: a branch resolved in EX
//   EX_PC             PC of the resolved branch
//   EX_condFlag       actual direction of the resolved branch
//   correct           resolver judged the prediction correct
//   branch_count      accepted updates (saturating)
//   mispredict_count  accepted updates with correct = 0 (saturating)

module branch_predictor #(
    parameter int unsigned DBITS      = 32,
    parameter int unsigned INDEX_BITS = 4,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned CNT_BITS   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [DBITS-1:0]    IF_PC,
    input  logic [3:0]          IF_opcode,
    output logic                prediction,
    output logic                ready,
    input  logic                update,
    input  logic [DBITS-1:0]    EX_PC,
    input  logic                EX_condFlag,
    input  logic                correct,
    output logic [CNT_BITS-1:0] branch_count,
    output logic [CNT_BITS-1:0] mispredict_count
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;
    localparam logic [3:0] OP_BRANCH = 4'b0010;
    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(ENTRIES - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [INDEX_BITS-1:0] ptr_q, ptr_d;
    logic                  ready_q;
    logic [1:0]            table_q [ENTRIES];
    logic [CNT_BITS-1:0]   branch_count_q, mispredict_count_q;

    logic [INDEX_BITS-1:0] rd_idx, ex_idx;
    logic [1:0]            ex_ctr, trained_ctr, rd_ctr;
    logic                  accept;

    logic                  tbl_we;
    logic [INDEX_BITS-1:0] tbl_widx;
    logic [1:0]            tbl_wdata;

    // PC bits outside the index field are intentionally ignored.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[DBITS-1:INDEX_BITS+2], IF_PC[1:0],
                              EX_PC[DBITS-1:INDEX_BITS+2], EX_PC[1:0]};

    assign rd_idx = IF_PC[INDEX_BITS+1:2];
    assign ex_idx = EX_PC[INDEX_BITS+1:2];

    // An update is only honoured in RUN, and a simultaneous clear drops it.
    assign accept = (state_q == S_RUN) && update && !clear;

    // Saturating counter step for the entry being trained.
    always_comb begin
        ex_ctr = table_q[ex_idx];
        trained_ctr = ex_ctr;
        if (EX_condFlag) begin
            if (ex_ctr != 2'b11) trained_ctr = ex_ctr + 2'd1;
        end else begin
            if (ex_ctr != 2'b00) trained_ctr = ex_ctr - 2'd1;
        end
    end

    // Write-to-read bypass: a same-index lookup sees the freshly trained value.
    always_comb begin
        rd_ctr = table_q[rd_idx];
        if (accept && (ex_idx == rd_idx)) rd_ctr = trained_ctr;
    end

    assign prediction = ready_q && (IF_opcode == OP_BRANCH) && rd_ctr[1];
    assign ready = ready_q;

    // Next-state: INIT walks the pointer and hands over to RUN on the same
    // edge that writes the last entry, so INIT lasts exactly ENTRIES cycles.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == S_INIT) begin
            if (clear) begin
                ptr_d = '0;
            end else if (ptr_q == LAST_IDX) begin
                state_d = S_RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr_q + INDEX_BITS'(1);
            end
        end else begin
            if (clear) begin
                state_d = S_INIT;
                ptr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ready_q <= (state_d == S_RUN);
        end
    end

    // Table write port: initialisation fill or training.
    always_comb begin
        tbl_we    = 1'b0;
        tbl_widx  = ex_idx;
        tbl_wdata = trained_ctr;
        if (state_q == S_INIT) begin
            tbl_we    = 1'b1;
            tbl_widx  = ptr_q;
            tbl_wdata = INIT_STATE;
        end else if (accept) begin
            tbl_we = 1'b1;
        end
    end

    // Table storage has no reset; INIT overwrites every entry.
    always_ff @(posedge clk) begin
        if (tbl_we) table_q[tbl_widx] <= tbl_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (accept) begin
            if (branch_count_q != CNT_MAX) begin
                branch_count_q <= branch_count_q + CNT_BITS'(1);
            end
            if (!correct && (mispredict_count_q != CNT_MAX)) begin
                mispredict_count_q <= mispredict_count_q + CNT_BITS'(1);
            end
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor. A second instance with 3-bit statistics
// counters shares all inputs so counter saturation is reachable in few cycles.

module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [31:0] IF_PC;
    logic [3:0]  IF_opcode;
    logic        update;
    logic [31:0] EX_PC;
    logic        EX_condFlag;
    logic        correct;

    logic        prediction, ready;
    logic [15:0] branch_count, mispredict_count;
    logic        prediction_s, ready_s;
    logic [2:0]  branch_count_s, mispredict_count_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor u_dut (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .IF_PC            (IF_PC),
        .IF_opcode        (IF_opcode),
        .prediction       (prediction),
        .ready            (ready),
        .update           (update),
        .EX_PC            (EX_PC),
        .EX_condFlag      (EX_condFlag),
        .correct          (correct),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    branch_predictor #(.CNT_BITS(3)) u_small (
        .clk              (clk),
        .reset            (reset),
        .clear            (clear),
        .IF_PC            (IF_PC),
        .IF_opcode        (IF_opcode),
        .prediction       (prediction_s),
        .ready            (ready_s),
        .update           (update),
        .EX_PC            (EX_PC),
        .EX_condFlag      (EX_condFlag),
        .correct          (correct),
        .branch_count     (branch_count_s),
        .mispredict_count (mispredict_count_s)
    );

    typedef struct {
        logic        upd;
        logic [31:0] ex_pc;
        logic        flag;
        logic        corr;
        logic [31:0] if_pc;
        logic [3:0]  op;
        logic        exp_pred;
        int          exp_bc;
        int          exp_mc;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int sat7(input int v);
        return (v > 7) ? 7 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, checking prediction stays low meanwhile.
    task automatic wait_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            if (prediction !== 1'b0) check("pred_in_init", {31'b0, prediction}, 32'd0);
            tick();
            n++;
        end
    endtask

    task automatic idle_inputs();
        clear = 1'b0; update = 1'b0; EX_PC = '0; EX_condFlag = 1'b0; correct = 1'b1;
    endtask

    int n;

    initial begin
        // upd ex_pc flag corr if_pc op exp_pred bc mc
        vecs[0]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h40, 4'h2, 1'b0, 0, 0};
        vecs[1]  = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h80, 4'h2, 1'b1, 1, 0};
        vecs[2]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h80, 4'h3, 1'b0, 1, 0};
        vecs[3]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 4'h2, 1'b0, 2, 1};
        vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h40, 4'h2, 1'b1, 2, 1};
        vecs[5]  = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h44, 4'h2, 1'b0, 2, 1};
        vecs[6]  = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 4'h2, 1'b1, 3, 1};
        vecs[7]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 4'h2, 1'b1, 4, 2};
        vecs[8]  = '{1'b1, 32'h40, 1'b1, 1'b0, 32'h40, 4'h2, 1'b1, 5, 3};
        vecs[9]  = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 4'h2, 1'b1, 6, 3};
        vecs[10] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 4'h2, 1'b1, 7, 3};
        vecs[11] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 4'h2, 1'b0, 8, 4};
        vecs[12] = '{1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 4'h2, 1'b0, 9, 4};
        vecs[13] = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h40, 4'h2, 1'b0, 10, 5};
        vecs[14] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h44, 4'h2, 1'b0, 11, 5};
        vecs[15] = '{1'b1, 32'h40, 1'b1, 1'b1, 32'h40, 4'h2, 1'b1, 12, 5};
        vecs[16] = '{1'b1, 32'h44, 1'b1, 1'b1, 32'h40, 4'h2, 1'b1, 13, 5};
        vecs[17] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h44, 4'h2, 1'b1, 13, 5};
        vecs[18] = '{1'b1, 32'h48, 1'b1, 1'b1, 32'h4C, 4'h2, 1'b0, 14, 5};
        vecs[19] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h43, 4'h2, 1'b1, 14, 5};

        // Reset and initialisation
        reset = 1'b1;
        idle_inputs();
        IF_PC = 32'h40; IF_opcode = 4'h2;
        #2;
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_bc", {16'b0, branch_count}, 32'd0);
        check("reset_mc", {16'b0, mispredict_count}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        // Updates during INIT must be dropped.
        update = 1'b1; EX_PC = 32'h40; EX_condFlag = 1'b1; correct = 1'b0;
        wait_ready(n);
        idle_inputs();
        check("init_cycles", n, 32'd16);
        check("ready_s", {31'b0, ready_s}, 32'd1);
        check("init_drop_bc", {16'b0, branch_count}, 32'd0);
        check("init_drop_mc", {16'b0, mispredict_count}, 32'd0);

        // Table-driven training vectors
        for (int i = 0; i < 20; i++) begin
            update = vecs[i].upd; EX_PC = vecs[i].ex_pc; EX_condFlag = vecs[i].flag;
            correct = vecs[i].corr; IF_PC = vecs[i].if_pc; IF_opcode = vecs[i].op;
            #1;
            check($sformatf("v%0d_pred", i), {31'b0, prediction}, {31'b0, vecs[i].exp_pred});
            check($sformatf("v%0d_pred_s", i), {31'b0, prediction_s},
                  {31'b0, vecs[i].exp_pred});
            tick();
            check($sformatf("v%0d_bc", i), {16'b0, branch_count}, vecs[i].exp_bc);
            check($sformatf("v%0d_mc", i), {16'b0, mispredict_count}, vecs[i].exp_mc);
            check($sformatf("v%0d_bc_s", i), {29'b0, branch_count_s}, sat7(vecs[i].exp_bc));
            check($sformatf("v%0d_mc_s", i), {29'b0, mispredict_count_s},
                  sat7(vecs[i].exp_mc));
        end
        idle_inputs();

        // Push the mispredict count past the small instance's all-ones value.
        for (int i = 0; i < 4; i++) begin
            update = 1'b1; EX_PC = 32'h60; EX_condFlag = 1'b0; correct = 1'b0;
            tick();
        end
        idle_inputs();
        check("sat_bc", {16'b0, branch_count}, 32'd18);
        check("sat_mc", {16'b0, mispredict_count}, 32'd9);
        check("sat_bc_s", {29'b0, branch_count_s}, 32'd7);
        check("sat_mc_s", {29'b0, mispredict_count_s}, 32'd7);

        // Clear together with update: clear wins, no bypass, no count.
        clear = 1'b1; update = 1'b1; EX_PC = 32'h44; EX_condFlag = 1'b0; correct = 1'b0;
        IF_PC = 32'h44; IF_opcode = 4'h2;
        #1;
        check("clr_no_bypass", {31'b0, prediction}, 32'd1);
        tick();
        idle_inputs();
        check("clr_ready", {31'b0, ready}, 32'd0);
        check("clr_bc", {16'b0, branch_count}, 32'd18);
        check("clr_mc", {16'b0, mispredict_count}, 32'd9);
        for (int i = 0; i < 5; i++) tick();
        check("clr_ready_mid", {31'b0, ready}, 32'd0);
        // Clear during INIT restarts the walk.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_ready(n);
        check("clr_restart_cycles", n, 32'd16);
        IF_PC = 32'h40;
        #1;
        check("clr_entry0", {31'b0, prediction}, 32'd0);
        IF_PC = 32'h44;
        #1;
        check("clr_entry1", {31'b0, prediction}, 32'd0);
        update = 1'b1; EX_PC = 32'h44; EX_condFlag = 1'b1; correct = 1'b1;
        #1;
        check("clr_init_state", {31'b0, prediction}, 32'd1);
        tick();
        idle_inputs();
        check("clr_bc_after", {16'b0, branch_count}, 32'd19);

        // Reset asserted with the INIT pointer at 7.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        #1;
        check("rst_mid_ready", {31'b0, ready}, 32'd0);
        check("rst_mid_bc", {16'b0, branch_count}, 32'd0);
        check("rst_mid_mc", {16'b0, mispredict_count}, 32'd0);
        check("rst_mid_bc_s", {29'b0, branch_count_s}, 32'd0);
        #1;
        reset = 1'b0;
        wait_ready(n);
        check("rst_mid_cycles", n, 32'd16);
        update = 1'b1; EX_PC = 32'h40; EX_condFlag = 1'b1; correct = 1'b0;
        tick();
        idle_inputs();
        check("rst_mid_bc_after", {16'b0, branch_count}, 32'd1);
        check("rst_mid_mc_after", {16'b0, mispredict_count}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
